cmd_seq: RTL and testbench

Parametrised command sequencer for the Knight's Tour system. It holds a programmable list of 16-bit commands (e.g. 16'h2000 calibrate, then moves) and plays them in order through a RemoteComm-style handshake. For each command it waits for a positive acknowledge byte, bounded by a per-command timeout. It sits between a host/BIST controller and RemoteComm, generalising the single-command "send, wait, check ack" flow to DEPTH commands with configurable timeout, ack value and error policy.

---
 rtl/cmd_seq_if.sv | 25 ++
 rtl/cmd_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_cmd_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_if.sv
// RemoteComm-side handshake bundle for cmd_seq: command word and send strobe out,
// transmit-complete and response byte back.
interface cmd_seq_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output send_cmd,
        input  cmd_sent,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  send_cmd,
        output cmd_sent,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/cmd_seq.sv
// Command sequencer: holds a list of 16-bit commands and plays them through the
// RemoteComm handshake, checking each ack against a per-command timeout.
module cmd_seq #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TMO_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK        = 8'hA5,
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [15:0]      wr_cmd_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             stop_on_err_i,
    cmd_seq_if.master        rc,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [IDX_W-1:0] err_idx_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned TMO_W = $clog2(TMO_CYCLES);

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_TMO   = 2'b01;
    localparam logic [1:0] E_NACK  = 2'b10;
    localparam logic [1:0] E_ABORT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gap_q, gap_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [IDX_W-1:0] eidx_q, eidx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      list_q [DEPTH];

    logic       busy;
    logic       full;
    logic       wr_ok;
    logic       tmo_hit;
    logic       last;
    logic       fail;
    logic       adv;
    logic [1:0] fail_code;

    assign busy    = (state_q != IDLE);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign wr_ok   = wr_en_i && !busy && !full && !clr_i;
    assign tmo_hit = (tmo_q == TMO_W'(TMO_CYCLES - 1));
    assign last    = (CNT_W'(idx_q) == count_q - CNT_W'(1));

    always_comb begin
        count_d = count_q;
        if (!busy && clr_i) begin
            count_d = '0;
        end else if (wr_ok) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // List storage carries no reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            list_q[count_q[IDX_W-1:0]] <= wr_cmd_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = 1'b0;
        tmo_d     = tmo_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        code_d    = code_q;
        eidx_d    = eidx_q;
        pass_d    = pass_q;
        fail      = 1'b0;
        fail_code = E_NONE;
        adv       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d  = 1'b0;
                    code_d = E_NONE;
                    eidx_d = '0;
                    pass_d = '0;
                    idx_d  = '0;
                    tmo_d  = '0;
                    if (count_d == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = SEND;
                        // A write landing with start in an empty list is slot 0 itself.
                        cmd_d   = (count_q == '0) ? wr_cmd_i : list_q[0];
                    end
                end
            end
            SEND: begin
                // After an advance SEND spends one quiet cycle fetching the next word.
                if (gap_q) begin
                    cmd_d = list_q[idx_q];
                    tmo_d = '0;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                    state_d = WAIT_SENT;
                end
            end
            WAIT_SENT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = E_TMO;
                end else if (rc.cmd_sent) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (rc.resp_rdy) begin
                    if (rc.resp == ACK) begin
                        pass_d = pass_q + CNT_W'(1);
                        adv    = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_NACK;
                    end
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = E_TMO;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
            if (!err_q) begin
                err_d  = 1'b1;
                code_d = fail_code;
                eidx_d = idx_q;
            end
            if (stop_on_err_i) begin
                state_d = FIN;
            end else begin
                adv = 1'b1;
            end
        end

        if (adv) begin
            if (last) begin
                state_d = FIN;
            end else begin
                state_d = SEND;
                idx_d   = idx_q + IDX_W'(1);
                gap_d   = 1'b1;
                tmo_d   = '0;
            end
        end

        // Abort overrides whatever the slot outcome would have been this cycle.
        if (abort_i && busy) begin
            state_d = IDLE;
            idx_d   = idx_q;
            gap_d   = 1'b0;
            tmo_d   = tmo_q;
            cmd_d   = cmd_q;
            pass_d  = pass_q;
            err_d   = err_q;
            code_d  = code_q;
            eidx_d  = eidx_q;
            if (!err_q) begin
                err_d  = 1'b1;
                code_d = E_ABORT;
                eidx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= 1'b0;
            tmo_q   <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
            eidx_q  <= '0;
            pass_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eidx_q  <= eidx_d;
            pass_q  <= pass_d;
            count_q <= count_d;
        end
    end

    assign rc.cmd      = cmd_q;
    assign rc.send_cmd = (state_q == SEND) && !gap_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == FIN);
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign err_idx_o   = eidx_q;
    assign pass_cnt_o  = pass_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = (count_q == '0);

endmodule

// File: tb/tb_cmd_seq.sv
// Directed bench for cmd_seq: table of playback scenarios plus hand-timed corner sequences.
`timescale 1ns/1ps
module tb_cmd_seq;
    localparam int DEPTH = 4;
    localparam int TMO   = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, clr, start, abort, stop;
    logic [15:0] wr_cmd;
    logic        busy_o, done_o, err_o, full_o, empty_o;
    logic [1:0]  err_code_o;
    logic [1:0]  err_idx_o;
    logic [2:0]  pass_cnt_o, count_o;

    always #5 clk = ~clk;

    cmd_seq_if sif ();

    cmd_seq #(.DEPTH(DEPTH), .TMO_CYCLES(TMO), .ACK(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en),
        .wr_cmd_i     (wr_cmd),
        .clr_i        (clr),
        .start_i      (start),
        .abort_i      (abort),
        .stop_on_err_i(stop),
        .rc           (sif.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .err_idx_o    (err_idx_o),
        .pass_cnt_o   (pass_cnt_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    typedef struct {
        int          n;
        logic [63:0] cmds;
        logic [31:0] rsp;
        logic [3:0]  silent;
        logic        stop;
        int          exp_sends;
        int          exp_pass;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t tbl [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [63:0] cmds);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_en  = 1'b1;
            wr_cmd = cmds[i*16 +: 16];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic send_ack(input logic [7:0] b);
        tick();
        sif.cmd_sent = 1'b1;
        tick();
        sif.cmd_sent = 1'b0;
        sif.resp     = b;
        sif.resp_rdy = 1'b1;
        tick();
        sif.resp_rdy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s;
        int waitc;
        int sends;
        bit fin;
        bit hung;
        load(v.n, v.cmds);
        stop  = v.stop;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = 0; sends = 0; waitc = 0; fin = 0; hung = 0;
        while (!fin && !hung) begin
            if (sif.send_cmd) begin
                if (s >= DEPTH) begin
                    hung = 1;
                end else begin
                    check({tag, ".cmd"}, sif.cmd, v.cmds[s*16 +: 16]);
                    sends++;
                    tick();
                    sif.cmd_sent = 1'b1;
                    tick();
                    sif.cmd_sent = 1'b0;
                    if (!v.silent[s]) begin
                        sif.resp     = v.rsp[s*8 +: 8];
                        sif.resp_rdy = 1'b1;
                        tick();
                        sif.resp_rdy = 1'b0;
                    end
                    s++;
                    waitc = 0;
                end
            end else if (done_o) begin
                fin = 1;
            end else begin
                tick();
                waitc++;
                if (waitc > 1200) hung = 1;
            end
        end
        check({tag, ".done_seen"}, fin, 1);
        check({tag, ".sends"}, sends, v.exp_sends);
        check({tag, ".pass_cnt"}, pass_cnt_o, v.exp_pass);
        check({tag, ".err"}, err_o, v.exp_err);
        check({tag, ".err_code"}, err_code_o, v.exp_code);
        check({tag, ".err_idx"}, err_idx_o, v.exp_idx);
        tick();
        check({tag, ".busy_after"}, busy_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n:2, cmds:64'h0000_0000_4001_2000, rsp:32'h0000_A5A5, silent:4'b0000, stop:1'b1,
                   exp_sends:2, exp_pass:2, exp_err:1'b0, exp_code:2'b00, exp_idx:2'd0};
        tbl[1] = '{n:3, cmds:64'h0000_5002_4001_2000, rsp:32'h00A5_5AA5, silent:4'b0000, stop:1'b1,
                   exp_sends:2, exp_pass:1, exp_err:1'b1, exp_code:2'b10, exp_idx:2'd1};
        tbl[2] = '{n:2, cmds:64'h0000_0000_4001_2000, rsp:32'h0000_A500, silent:4'b0001, stop:1'b0,
                   exp_sends:2, exp_pass:1, exp_err:1'b1, exp_code:2'b01, exp_idx:2'd0};
        tbl[3] = '{n:4, cmds:64'h6003_5002_4001_2000, rsp:32'hFFA5_00A5, silent:4'b0000, stop:1'b0,
                   exp_sends:4, exp_pass:2, exp_err:1'b1, exp_code:2'b10, exp_idx:2'd1};
        tbl[4] = '{n:3, cmds:64'h0000_5002_4001_2000, rsp:32'h0000_00A5, silent:4'b0010, stop:1'b1,
                   exp_sends:2, exp_pass:1, exp_err:1'b1, exp_code:2'b01, exp_idx:2'd1};

        rst_n = 1'b0; wr_en = 0; clr = 0; start = 0; abort = 0; stop = 0; wr_cmd = '0;
        sif.cmd_sent = 0; sif.resp_rdy = 0; sif.resp = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst.cmd", sif.cmd, 0);
        check("rst.send_cmd", sif.send_cmd, 0);
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        check("rst.err", {err_o, err_code_o, err_idx_o}, 0);
        check("rst.pass_cnt", pass_cnt_o, 0);
        check("rst.count", count_o, 0);
        check("rst.empty", empty_o, 1);
        check("rst.full", full_o, 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Handshake timing: send at N+1, gap after ack, next send at M+2, done at M+1.
        load(2, 64'h4001_2000);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tim.busy_n1", busy_o, 1);
        check("tim.send_n1", sif.send_cmd, 1);
        check("tim.cmd_n1", sif.cmd, 16'h2000);
        send_ack(8'hA5);
        check("tim.send_m1", sif.send_cmd, 0);
        check("tim.cmd_hold_m1", sif.cmd, 16'h2000);
        tick();
        check("tim.send_m2", sif.send_cmd, 1);
        check("tim.cmd_m2", sif.cmd, 16'h4001);
        send_ack(8'hA5);
        check("tim.done_m1", done_o, 1);
        check("tim.busy_m1", busy_o, 1);
        tick();
        check("tim.done_m2", done_o, 0);
        check("tim.busy_m2", busy_o, 0);
        check("tim.pass", pass_cnt_o, 2);

        // Timeout lands exactly TMO cycles after the send pulse.
        load(1, 64'h2000);
        stop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sif.cmd_sent = 1'b1;
        tick();
        sif.cmd_sent = 1'b0;
        repeat (997) tick();
        check("tmo.err_s999", err_o, 0);
        tick();
        check("tmo.err_s1000", err_o, 1);
        check("tmo.code", err_code_o, 2'b01);
        check("tmo.done", done_o, 1);
        tick();

        // Response on the expiry cycle beats the timeout.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sif.cmd_sent = 1'b1;
        tick();
        sif.cmd_sent = 1'b0;
        repeat (997) tick();
        sif.resp     = 8'hA5;
        sif.resp_rdy = 1'b1;
        tick();
        sif.resp_rdy = 1'b0;
        check("race.err", err_o, 0);
        check("race.pass", pass_cnt_o, 1);
        check("race.done", done_o, 1);
        tick();

        // Overfill, clear, and an empty run.
        load(4, 64'h6003_5002_4001_2000);
        wr_en  = 1'b1;
        wr_cmd = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        check("full.full", full_o, 1);
        check("full.count", count_o, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr.empty", empty_o, 1);
        check("clr.count", count_o, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty.done", done_o, 1);
        check("empty.send", sif.send_cmd, 0);
        check("empty.pass", pass_cnt_o, 0);
        tick();
        check("empty.busy", busy_o, 0);

        // Abort in WAIT_RESP, then replay from slot 0.
        load(2, 64'h4001_2000);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sif.cmd_sent = 1'b1;
        tick();
        sif.cmd_sent = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", busy_o, 0);
        check("abort.err", err_o, 1);
        check("abort.code", err_code_o, 2'b11);
        check("abort.done", done_o, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("replay.send", sif.send_cmd, 1);
        check("replay.cmd", sif.cmd, 16'h2000);
        check("replay.err", {err_o, err_code_o}, 0);
        send_ack(8'hA5);
        tick();
        check("replay.cmd1", sif.cmd, 16'h4001);
        send_ack(8'hA5);
        check("replay.done", done_o, 1);
        check("replay.pass", pass_cnt_o, 2);
        tick();

        // Abort coincident with an ack: abort wins, no pass credit.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sif.cmd_sent = 1'b1;
        tick();
        sif.cmd_sent = 1'b0;
        sif.resp     = 8'hA5;
        sif.resp_rdy = 1'b1;
        abort        = 1'b1;
        tick();
        sif.resp_rdy = 1'b0;
        abort        = 1'b0;
        check("abort_ack.pass", pass_cnt_o, 0);
        check("abort_ack.busy", busy_o, 0);
        check("abort_ack.code", err_code_o, 2'b11);

        // Start together with a write into an empty list.
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        wr_en  = 1'b1;
        wr_cmd = 16'h7777;
        start  = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check("stwr.send", sif.send_cmd, 1);
        check("stwr.cmd", sif.cmd, 16'h7777);
        check("stwr.count", count_o, 1);
        send_ack(8'hA5);
        check("stwr.done", done_o, 1);
        check("stwr.pass", pass_cnt_o, 1);
        tick();

        // Asynchronous reset in WAIT_SENT.
        load(2, 64'h4001_2000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", busy_o, 0);
        check("arst.count", count_o, 0);
        check("arst.empty", empty_o, 1);
        check("arst.cmd", sif.cmd, 0);
        check("arst.pass", pass_cnt_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst.count_after", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
